// File: rtl/game_sequencer.sv
// Round controller for the three-lane arithmetic game: owns the IDLE/PLAY/OVER
// state, paces lane advances with a level-dependent period, charges missed
// expressions against life and freezes the drop timer while an answer is handled.
module game_sequencer #(
    parameter int INIT_LIFE   = 2,
    parameter int BASE_PERIOD = 512,
    parameter int PERIOD_STEP = 64,
    parameter int MIN_PERIOD  = 128,
    parameter int LEVEL_SCORE = 50,
    parameter int MAX_LEVEL   = 7
) (
    input  logic        delay_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        submit_valid,
    input  logic [2:0]  bottom_occupied,
    input  logic [15:0] score,
    output logic [1:0]  state,
    output logic        advance,
    output logic        clear_all,
    output logic [1:0]  life,
    output logic [2:0]  level,
    output logic        game_over
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_OVER = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [1:0]  life_q, life_d;
    logic [2:0]  level_q, level_d;
    logic        adv_q, adv_d;
    logic        clr_q, clr_d;
    logic        go_q, go_d;

    logic [10:0] dec, period, period_m1;
    logic        term;
    logic [1:0]  misses, life_hit;
    logic [16:0] lvl_thr;

    // Advance period from the current level, clamped at the minimum; a
    // shrinking period that falls below cnt terminates on the next compare.
    always_comb begin
        dec = 11'(level_q) * 11'(PERIOD_STEP);
        if (dec >= 11'(BASE_PERIOD) || (11'(BASE_PERIOD) - dec) < 11'(MIN_PERIOD))
            period = 11'(MIN_PERIOD);
        else
            period = 11'(BASE_PERIOD) - dec;
        period_m1 = period - 11'd1;
        term      = {1'b0, cnt_q} >= period_m1;
        misses    = {1'b0, bottom_occupied[0]} + {1'b0, bottom_occupied[1]}
                  + {1'b0, bottom_occupied[2]};
        life_hit  = (misses >= life_q) ? 2'd0 : life_q - misses;
        lvl_thr   = (17'(level_q) + 17'd1) * 17'(LEVEL_SCORE);
    end

    // Next-state: game flow, drop timer, miss charging and level tracking.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        life_d  = life_q;
        level_d = level_q;
        adv_d   = 1'b0;
        clr_d   = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d = S_PLAY;
                    clr_d   = 1'b1;
                    life_d  = 2'(INIT_LIFE);
                    level_d = 3'd0;
                    cnt_d   = 10'd0;
                end
            end
            S_PLAY: begin
                // Answer handling pauses the timer without resetting it.
                if (!submit_valid) begin
                    if (!term) begin
                        cnt_d = cnt_q + 10'd1;
                    end else begin
                        adv_d  = 1'b1;
                        cnt_d  = 10'd0;
                        life_d = life_hit;
                        if (life_hit == 2'd0)
                            state_d = S_OVER;
                    end
                end
                if (level_q < 3'(MAX_LEVEL) && {1'b0, score} >= lvl_thr)
                    level_d = level_q + 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
        go_d = (state_d == S_OVER);
    end

    // State and registered outputs, asynchronously cleared.
    always_ff @(posedge delay_clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 10'd0;
            life_q  <= 2'(INIT_LIFE);
            level_q <= 3'd0;
            adv_q   <= 1'b0;
            clr_q   <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            life_q  <= life_d;
            level_q <= level_d;
            adv_q   <= adv_d;
            clr_q   <= clr_d;
            go_q    <= go_d;
        end
    end

    assign state     = state_q;
    assign advance   = adv_q;
    assign clear_all = clr_q;
    assign life      = life_q;
    assign level     = level_q;
    assign game_over = go_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: timing of advances, pause on answer,
// level-dependent period, life loss / game over, restart and async reset.
module tb_game_sequencer;

    logic        delay_clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        submit_valid = 1'b0;
    logic [2:0]  bottom_occupied = 3'b000;
    logic [15:0] score = 16'd0;
    logic [1:0]  state;
    logic        advance;
    logic        clear_all;
    logic [1:0]  life;
    logic [2:0]  level;
    logic        game_over;

    int n_chk = 0;
    int n_err = 0;

    game_sequencer dut (
        .delay_clk(delay_clk), .rst(rst), .start(start),
        .submit_valid(submit_valid), .bottom_occupied(bottom_occupied),
        .score(score), .state(state), .advance(advance),
        .clear_all(clear_all), .life(life), .level(level),
        .game_over(game_over)
    );

    always #5 delay_clk = ~delay_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts negedges (starting from n0) until advance is seen; -1 on timeout.
    task automatic wait_adv(input int n0, output int n);
        n = n0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge delay_clk);
            n++;
            if (advance) return;
        end
        n = -1;
    endtask

    task automatic pulse_start();
        @(negedge delay_clk);
        start = 1'b1;
        @(negedge delay_clk);
        start = 1'b0;
    endtask

    int n, spur;

    initial begin
        // Reset values
        repeat (3) @(negedge delay_clk);
        chk("rst_state", state, 0);
        chk("rst_adv", advance, 0);
        chk("rst_clr", clear_all, 0);
        chk("rst_life", life, 2);
        chk("rst_level", level, 0);
        chk("rst_go", game_over, 0);
        rst = 1'b1;
        repeat (5) @(negedge delay_clk);
        chk("idle_hold", state, 0);

        // Start: one-cycle clear, PLAY, nominal 512 period
        pulse_start();
        chk("start_clr", clear_all, 1);
        chk("start_state", state, 1);
        @(negedge delay_clk);
        chk("clr_one_cycle", clear_all, 0);
        wait_adv(1, n);
        chk("first_period", n, 512);
        wait_adv(0, n);
        chk("second_period", n, 512);

        // Pause at cnt=300 for 10 cycles; start in PLAY is ignored
        spur = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge delay_clk);
            if (advance) spur++;
            if (i == 100) start = 1'b1;
            if (i == 101) begin
                start = 1'b0;
                chk("play_start_ign", {30'd0, state} + (clear_all ? 32'd4 : 32'd0), 1);
            end
        end
        submit_valid = 1'b1;
        repeat (10) begin
            @(negedge delay_clk);
            if (advance) spur++;
        end
        submit_valid = 1'b0;
        chk("pause_no_adv", spur, 0);
        wait_adv(310, n);
        chk("paused_period", n, 522);
        wait_adv(0, n);
        chk("after_pause_period", n, 512);

        // Score 120 -> level 2, period 384
        score = 16'd120;
        repeat (2) @(negedge delay_clk);
        chk("level2", level, 2);
        wait_adv(0, n);
        wait_adv(0, n);
        chk("period_lvl2", n, 384);

        // Score 1000 -> level 7, period clamped at 128
        score = 16'd1000;
        repeat (6) @(negedge delay_clk);
        chk("level7", level, 7);
        wait_adv(0, n);
        wait_adv(0, n);
        chk("period_lvl7", n, 128);

        // Two misses with life 2 -> OVER on the final advance
        bottom_occupied = 3'b011;
        wait_adv(0, n);
        chk("final_adv_period", n, 128);
        chk("over_life", life, 0);
        chk("over_state", state, 2);
        chk("over_go", game_over, 1);
        bottom_occupied = 3'b000;
        spur = 0;
        repeat (2000) begin
            @(negedge delay_clk);
            if (advance) spur++;
        end
        chk("over_no_adv", spur, 0);
        chk("over_hold", state, 2);

        // Restart from OVER
        pulse_start();
        chk("restart_state", state, 1);
        chk("restart_clr", clear_all, 1);
        chk("restart_life", life, 2);
        chk("restart_level", level, 0);
        chk("restart_go", game_over, 0);
        bottom_occupied = 3'b001;
        wait_adv(0, n);
        chk("one_miss_life", life, 1);
        chk("one_miss_state", state, 1);
        bottom_occupied = 3'b111;
        wait_adv(0, n);
        chk("sat_life", life, 0);
        chk("sat_state", state, 2);

        // Async reset mid-PLAY
        score = 16'd60;
        bottom_occupied = 3'b001;
        pulse_start();
        wait_adv(0, n);
        chk("pre_rst_life", life, 1);
        bottom_occupied = 3'b000;
        repeat (200) @(negedge delay_clk);
        chk("pre_rst_level", level, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_life", life, 2);
        chk("arst_level", level, 0);
        chk("arst_adv", advance, 0);
        chk("arst_clr", clear_all, 0);
        chk("arst_go", game_over, 0);
        @(negedge delay_clk);
        rst = 1'b1;
        spur = 0;
        repeat (20) begin
            @(negedge delay_clk);
            if (advance || state != 2'b00) spur++;
        end
        chk("post_rst_idle", spur, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
